// File: rtl/regfile_read_stage_pkg.sv
// Shared constants for the RV32I integer register file read path.
// Datapath width, register index width, instruction field positions and the x0 index.
// The decoder and the hazard unit use the same definitions.
package regfile_read_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // LSB positions of the register fields inside an RV32I instruction word
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned RD_LSB  = 7;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t X0 = '0;

endpackage

// File: rtl/operand_bypass_mux.sv
// Source operand select for one register-file read port.
// Ports:
//   idx_i       register index being read
//   rf_data_i   raw register-file read data for idx_i
//   wb_we_i     writeback write enable
//   wb_rd_i     writeback destination index
//   wb_result_i writeback data
//   operand_o   selected operand (combinational)
module operand_bypass_mux
    import regfile_read_stage_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] idx_i,
    input  logic [XLEN-1:0]       rf_data_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]       wb_result_i,
    output logic [XLEN-1:0]       operand_o
);

    // x0 wins over everything: neither the array content nor a write to x0 is trusted.
    // A matching writeback in this cycle has not reached the array yet, so forward it.
    always_comb begin
        operand_o = rf_data_i;
        if (idx_i == X0) begin
            operand_o = '0;
        end else if (wb_we_i && (wb_rd_i == idx_i)) begin
            operand_o = wb_result_i;
        end
    end

endmodule

// File: rtl/regfile_read_stage.sv
// Register-file read stage and ID/EX pipeline register of the RV32I core.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   instr_d, pc_d, pcplus4_d,
//   valid_d                       decode-stage slot
//   rf_a1, rf_a2                  register-file read addresses (combinational)
//   rf_rd1, rf_rd2                register-file read data
//   wb_we, wb_rd, wb_result       writeback port, used for same-cycle bypass
//   stall_e, flush_e              hazard-unit control of the ID/EX register
//   rs1_data_e .. valid_e         ID/EX register contents
//   bubble_cnt                    saturating count of flush-inserted bubbles
module regfile_read_stage
    import regfile_read_stage_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       instr_d,
    input  logic [XLEN-1:0]       pc_d,
    input  logic [XLEN-1:0]       pcplus4_d,
    input  logic                  valid_d,
    output logic [REG_ADDR_W-1:0] rf_a1,
    output logic [REG_ADDR_W-1:0] rf_a2,
    input  logic [XLEN-1:0]       rf_rd1,
    input  logic [XLEN-1:0]       rf_rd2,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_result,
    input  logic                  stall_e,
    input  logic                  flush_e,
    output logic [XLEN-1:0]       rs1_data_e,
    output logic [XLEN-1:0]       rs2_data_e,
    output logic [REG_ADDR_W-1:0] rs1_e,
    output logic [REG_ADDR_W-1:0] rs2_e,
    output logic [REG_ADDR_W-1:0] rd_e,
    output logic [XLEN-1:0]       instr_e,
    output logic [XLEN-1:0]       pc_e,
    output logic [XLEN-1:0]       pcplus4_e,
    output logic                  valid_e,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic [REG_ADDR_W-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0]       op1, op2;

    logic [XLEN-1:0]       rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0]       instr_q, instr_d_n, pc_q, pc_n, pcplus4_q, pcplus4_n;
    logic                  valid_q, valid_n;
    logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;

    assign rs1_idx = instr_d[RS1_LSB +: REG_ADDR_W];
    assign rs2_idx = instr_d[RS2_LSB +: REG_ADDR_W];
    assign rd_idx  = instr_d[RD_LSB +: REG_ADDR_W];

    assign rf_a1 = rs1_idx;
    assign rf_a2 = rs2_idx;

    operand_bypass_mux u_op1 (
        .idx_i       (rs1_idx),
        .rf_data_i   (rf_rd1),
        .wb_we_i     (wb_we),
        .wb_rd_i     (wb_rd),
        .wb_result_i (wb_result),
        .operand_o   (op1)
    );

    operand_bypass_mux u_op2 (
        .idx_i       (rs2_idx),
        .rf_data_i   (rf_rd2),
        .wb_we_i     (wb_we),
        .wb_rd_i     (wb_rd),
        .wb_result_i (wb_result),
        .operand_o   (op2)
    );

    // Flush beats stall; a stall holds every field including the already-selected operands.
    always_comb begin
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        instr_d_n    = instr_q;
        pc_n         = pc_q;
        pcplus4_n    = pcplus4_q;
        valid_n      = valid_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush_e) begin
            rs1_data_d = '0;
            rs2_data_d = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            instr_d_n  = '0;
            pc_n       = '0;
            pcplus4_n  = '0;
            valid_n    = 1'b0;
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else if (!stall_e) begin
            rs1_data_d = op1;
            rs2_data_d = op2;
            rs1_d      = rs1_idx;
            rs2_d      = rs2_idx;
            rd_d       = rd_idx;
            instr_d_n  = instr_d;
            pc_n       = pc_d;
            pcplus4_n  = pcplus4_d;
            valid_n    = valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            instr_q      <= '0;
            pc_q         <= '0;
            pcplus4_q    <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            instr_q      <= instr_d_n;
            pc_q         <= pc_n;
            pcplus4_q    <= pcplus4_n;
            valid_q      <= valid_n;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign rs1_data_e = rs1_data_q;
    assign rs2_data_e = rs2_data_q;
    assign rs1_e      = rs1_q;
    assign rs2_e      = rs2_q;
    assign rd_e       = rd_q;
    assign instr_e    = instr_q;
    assign pc_e       = pc_q;
    assign pcplus4_e  = pcplus4_q;
    assign valid_e    = valid_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_regfile_read_stage.sv
module tb_regfile_read_stage;

    localparam int unsigned CntW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_d, pc_d, pcplus4_d;
    logic        valid_d;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        stall_e, flush_e;
    logic [31:0] rs1_data_e, rs2_data_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic [31:0] instr_e, pc_e, pcplus4_e;
    logic        valid_e;
    logic [CntW-1:0] bubble_cnt;

    regfile_read_stage #(.CNT_W(CntW)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d),
        .rf_a1      (rf_a1),
        .rf_a2      (rf_a2),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_result  (wb_result),
        .stall_e    (stall_e),
        .flush_e    (flush_e),
        .rs1_data_e (rs1_data_e),
        .rs2_data_e (rs2_data_e),
        .rs1_e      (rs1_e),
        .rs2_e      (rs2_e),
        .rd_e       (rd_e),
        .instr_e    (instr_e),
        .pc_e       (pc_e),
        .pcplus4_e  (pcplus4_e),
        .valid_e    (valid_e),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     rs1_data, rs2_data, instr, pc, pcp4;
        logic [4:0]      rs1, rs2, rd;
        logic            valid;
        logic [CntW-1:0] bub;
    } exp_t;

    exp_t exp_q[$];
    exp_t model;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sel(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
        if (wb_we && wb_rd == idx) return wb_result;
        return rf;
    endfunction

    // Build expected ID/EX contents from the current inputs, clock once, then compare.
    task automatic step();
        exp_t e;
        exp_t got;
        logic [4:0] a1, a2;
        a1 = instr_d[19:15];
        a2 = instr_d[24:20];
        check("rf_a1", {27'd0, rf_a1}, {27'd0, a1});
        check("rf_a2", {27'd0, rf_a2}, {27'd0, a2});
        e = model;
        if (rst || flush_e) begin
            e.rs1_data = 0; e.rs2_data = 0; e.instr = 0; e.pc = 0; e.pcp4 = 0;
            e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.valid = 0;
            if (rst) e.bub = 0;
            else if (model.bub != {CntW{1'b1}}) e.bub = model.bub + 1'b1;
        end else if (!stall_e) begin
            e.rs1_data = sel(a1, rf_rd1);
            e.rs2_data = sel(a2, rf_rd2);
            e.rs1 = a1;
            e.rs2 = a2;
            e.rd = instr_d[11:7];
            e.instr = instr_d;
            e.pc = pc_d;
            e.pcp4 = pcplus4_d;
            e.valid = valid_d;
        end
        exp_q.push_back(e);
        model = e;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("rs1_data_e", rs1_data_e, got.rs1_data);
        check("rs2_data_e", rs2_data_e, got.rs2_data);
        check("rs1_e", {27'd0, rs1_e}, {27'd0, got.rs1});
        check("rs2_e", {27'd0, rs2_e}, {27'd0, got.rs2});
        check("rd_e", {27'd0, rd_e}, {27'd0, got.rd});
        check("instr_e", instr_e, got.instr);
        check("pc_e", pc_e, got.pc);
        check("pcplus4_e", pcplus4_e, got.pcp4);
        check("valid_e", {31'd0, valid_e}, {31'd0, got.valid});
        check("bubble_cnt", {28'd0, bubble_cnt}, {28'd0, got.bub});
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2);
        instr_d   = ins;
        rf_rd1    = d1;
        rf_rd2    = d2;
        pc_d      = $urandom;
        pcplus4_d = pc_d + 32'd4;
    endtask

    initial begin
        model = '{default: '0};
        // 1: reset with garbage on every input
        rst = 1'b1; valid_d = 1'b1; wb_we = 1'b1; wb_rd = 5'd7; wb_result = $urandom;
        stall_e = 1'b1; flush_e = 1'b1;
        drive($urandom, $urandom, $urandom);
        step();
        stall_e = 1'b0;
        drive($urandom, $urandom, $urandom);
        step();
        check("rst_valid", {31'd0, valid_e}, 32'd0);
        rst = 1'b0; flush_e = 1'b0; wb_we = 1'b0;

        // 2: add x4,x2,x3
        drive(32'h0031_0233, 32'h11, 32'h22);
        check("t2_a1", {27'd0, rf_a1}, 32'd2);
        check("t2_a2", {27'd0, rf_a2}, 32'd3);
        step();
        check("t2_rs1", rs1_data_e, 32'h11);
        check("t2_rs2", rs2_data_e, 32'h22);
        check("t2_rd", {27'd0, rd_e}, 32'd4);

        // 3: rs1=x0, write to x0 must not bypass
        drive(32'h0030_0233, 32'hDEAD, 32'h22);
        wb_we = 1'b1; wb_rd = 5'd0; wb_result = 32'hBEEF;
        step();
        check("t3_x0", rs1_data_e, 32'd0);

        // 4: bypass on rs2=x3, then no bypass
        drive(32'h0031_0233, 32'h11, 32'h22);
        wb_rd = 5'd3; wb_result = 32'h99;
        step();
        check("t4_byp", rs2_data_e, 32'h99);
        wb_we = 1'b0;
        step();
        check("t4_nobyp", rs2_data_e, 32'h22);

        // 5: stall for 3 cycles with changing inputs, then flush+stall
        stall_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, $urandom);
            wb_we = 1'b1; wb_rd = instr_d[19:15]; wb_result = $urandom;
            step();
        end
        check("t5_hold", rs2_data_e, 32'h22);
        flush_e = 1'b1;
        step();
        check("t5_flush_cnt", {28'd0, bubble_cnt}, 32'd1);
        stall_e = 1'b0; flush_e = 1'b0; wb_we = 1'b0;

        // valid_d=0 loads normally and does not count as a bubble
        valid_d = 1'b0;
        drive($urandom, $urandom, $urandom);
        step();
        valid_d = 1'b1;

        // random mix
        for (int i = 0; i < 40; i++) begin
            drive($urandom, $urandom, $urandom);
            valid_d   = 1'($urandom_range(0, 1));
            wb_we     = 1'($urandom_range(0, 1));
            wb_rd     = $urandom_range(0, 1) ? instr_d[24:20] : 5'($urandom);
            wb_result = $urandom;
            stall_e   = ($urandom_range(0, 3) == 0);
            flush_e   = ($urandom_range(0, 5) == 0);
            step();
        end
        stall_e = 1'b0;

        // 6: saturation, then reset mid-flush
        flush_e = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive($urandom, $urandom, $urandom);
            step();
        end
        check("t6_sat", {28'd0, bubble_cnt}, 32'd15);
        rst = 1'b1;
        step();
        check("t6_rst", {28'd0, bubble_cnt}, 32'd0);
        rst = 1'b0; flush_e = 1'b0;
        drive(32'h0031_0233, 32'h5, 32'h6);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
